// File: rtl/freq_monitor_pkg.sv
// Shared state encoding and width helper for the divided-clock frequency monitor.
package freq_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } fm_state_e;

  // Smallest bit count able to represent value (at least 1 bit).
  function automatic int calc_bits(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((value >> i) != 0) begin
        bits = i + 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Brings an asynchronous generated clock into the clk domain as data and
// emits a registered one-cycle pulse for each rising edge it carries.
module edge_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;
  logic rise_q;

  // Two synchronizer stages, a history stage, and the registered edge pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= sig_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/freq_monitor.sv
// Measures the period of a divided clock in system cycles, tracks lock
// against the nominal ratio and flags loss of the monitored signal.
module freq_monitor
  import freq_monitor_pkg::*;
#(
  parameter int  CLK_FPGA     = 50_000_000,
  parameter int  FREQ_DIVISOR = 5_000_000,
  parameter int  TOLERANCE    = 1,
  parameter int  LOCK_PERIODS = 4,
  localparam int EXPECTED     = CLK_FPGA / FREQ_DIVISOR,
  localparam int TIMEOUT      = 2 * EXPECTED,
  localparam int CNT_W        = calc_bits(TIMEOUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_Signal,
  output logic [CNT_W-1:0] period_count,
  output logic             period_valid,
  output logic             locked,
  output logic             lost,
  output logic [7:0]       err_count
);

  localparam int GOOD_W = calc_bits(LOCK_PERIODS);
  localparam logic [CNT_W-1:0]  EXP_C  = CNT_W'(EXPECTED);
  localparam logic [CNT_W-1:0]  TMO_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  TOL_C  = CNT_W'(TOLERANCE);
  localparam logic [GOOD_W-1:0] LOCK_C = GOOD_W'(LOCK_PERIODS);

  logic              rise_s;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  dev_s;
  logic              period_good_s;
  logic [GOOD_W-1:0] good_q;
  logic [GOOD_W-1:0] good_inc_s;
  logic [7:0]        err_q;
  logic [7:0]        err_inc_s;
  fm_state_e         state_q;
  logic [CNT_W-1:0]  period_count_q;
  logic              period_valid_q;
  logic              locked_q;
  logic              lost_q;

  edge_sync u_edge_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .sig_i   (clk_Signal),
    .rise_o  (rise_s)
  );

  // Counter next state, period deviation and saturating increments.
  always_comb begin
    cnt_d = cnt_q;
    if (rise_s) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q < TMO_C) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    dev_s         = (cnt_q >= EXP_C) ? (cnt_q - EXP_C) : (EXP_C - cnt_q);
    period_good_s = (dev_s <= TOL_C);
    good_inc_s    = (good_q == LOCK_C) ? good_q : (good_q + GOOD_W'(1));
    err_inc_s     = (err_q == 8'hFF) ? err_q : (err_q + 8'd1);
  end

  // Cycles since the last synchronized rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Measurement FSM; a rise coinciding with the timeout is still a period.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      good_q         <= {GOOD_W{1'b0}};
      err_q          <= 8'd0;
      period_count_q <= {CNT_W{1'b0}};
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise_s) begin
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise_s) begin
            period_count_q <= cnt_q;
            period_valid_q <= 1'b1;
            if (period_good_s) begin
              good_q   <= good_inc_s;
              locked_q <= (good_inc_s == LOCK_C);
            end else begin
              good_q   <= {GOOD_W{1'b0}};
              locked_q <= 1'b0;
              err_q    <= err_inc_s;
            end
          end else if (cnt_q == TMO_C) begin
            state_q  <= LOST;
            lost_q   <= 1'b1;
            locked_q <= 1'b0;
            good_q   <= {GOOD_W{1'b0}};
            err_q    <= err_inc_s;
          end
        end
        LOST: begin
          if (rise_s) begin
            state_q <= MEASURE;
            lost_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign period_count = period_count_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign lost         = lost_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_freq_monitor.sv
// Directed scoreboard bench for freq_monitor: expected reports and loss
// events are queued by the stimulus and consumed by an independent monitor.
module tb_freq_monitor;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       clk_Signal = 1'b0;
  logic [4:0] period_count;
  logic       period_valid;
  logic       locked;
  logic       lost;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cnt;
    bit lck;
    int err;
  } rep_t;

  rep_t rep_q[$];
  int   lost_q[$];
  rep_t exp_r;
  int   exp_lost_err;
  int   since_pv  = 0;
  bit   lost_prev = 1'b0;

  freq_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .clk_Signal   (clk_Signal),
    .period_count (period_count),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_rep(input int c, input bit l, input int e);
    rep_t r;
    r.cnt = c;
    r.lck = l;
    r.err = e;
    rep_q.push_back(r);
  endtask

  // One monitored period: rising edge, hi cycles high, lo cycles low.
  task automatic pulse(input int hi, input int lo);
    clk_Signal = 1'b1;
    repeat (hi) @(negedge clk);
    clk_Signal = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period_count"}, int'(period_count), 0);
    check({tag, "_period_valid"}, int'(period_valid), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_lost"}, int'(lost), 0);
    check({tag, "_err_count"}, int'(err_count), 0);
  endtask

  // Monitor: consume an expectation for every report and every loss event.
  always @(negedge clk) begin
    if (period_valid) begin
      since_pv = 0;
      check("report_expected", int'(rep_q.size() != 0), 1);
      if (rep_q.size() != 0) begin
        exp_r = rep_q.pop_front();
        check("period_count", int'(period_count), exp_r.cnt);
        check("locked", int'(locked), int'(exp_r.lck));
        check("err_count", int'(err_count), exp_r.err);
        check("lost_at_report", int'(lost), 0);
      end
    end else begin
      since_pv++;
    end
    if (lost && !lost_prev) begin
      check("lost_expected", int'(lost_q.size() != 0), 1);
      if (lost_q.size() != 0) begin
        exp_lost_err = lost_q.pop_front();
        check("lost_delay", since_pv, 20);
        check("lost_locked", int'(locked), 0);
        check("lost_err_count", int'(err_count), exp_lost_err);
      end
    end
    lost_prev = lost;
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("por");
    reset = 1'b0;

    // Nominal 10-cycle periods lock on the 4th report, then 9 (good) and 8 (bad).
    for (int i = 0; i < 6; i++) expect_rep(10, i >= 3, 0);
    expect_rep(9, 1'b1, 0);
    expect_rep(8, 1'b0, 1);
    for (int i = 0; i < 4; i++) expect_rep(10, i == 3, 1);
    expect_rep(20, 1'b0, 2);
    for (int i = 0; i < 4; i++) expect_rep(10, i == 3, 2);
    lost_q.push_back(3);
    for (int i = 0; i < 4; i++) expect_rep(10, i == 3, 3);

    repeat (6) pulse(5, 5);
    pulse(5, 4);
    pulse(4, 4);
    repeat (4) pulse(5, 5);
    pulse(10, 10);
    repeat (4) pulse(5, 5);
    pulse(5, 30);
    repeat (4) pulse(5, 5);

    // Reset pulse during the low phase of a locked period.
    clk_Signal = 1'b1;
    repeat (5) @(negedge clk);
    clk_Signal = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_locked", int'(locked), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero("mid_reset");
    check("pre_reset_reports_drained", rep_q.size(), 0);
    repeat (3) @(negedge clk);

    // After reset the first rise is silent; then a 10 report and 260 bad 12s.
    expect_rep(10, 1'b0, 0);
    for (int i = 1; i <= 260; i++) expect_rep(12, 1'b0, (i < 255) ? i : 255);
    pulse(5, 5);
    repeat (260) pulse(6, 6);
    clk_Signal = 1'b1;
    for (int i = 0; i < 20 && rep_q.size() != 0; i++) @(negedge clk);

    check("reports_drained", rep_q.size(), 0);
    check("lost_events_drained", lost_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
